// File: rtl/bus_frame_pkg.sv
// rtl/bus_frame_pkg.sv - frame phase numbering, memory FSM states and return-lane helper
package bus_frame_pkg;

  localparam int FRAME_LEN = 10;

  localparam logic [3:0] PH_IDLE = 4'd0;
  localparam logic [3:0] PH_A0   = 4'd1;
  localparam logic [3:0] PH_A1   = 4'd2;
  localparam logic [3:0] PH_A2   = 4'd3;
  localparam logic [3:0] PH_A3   = 4'd4;
  localparam logic [3:0] PH_RW   = 4'd5;
  localparam logic [3:0] PH_D0   = 4'd6;
  localparam logic [3:0] PH_D1   = 4'd7;
  localparam logic [3:0] PH_D2   = 4'd8;
  localparam logic [3:0] PH_D3   = 4'd9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_REQ = 2'd1,
    WR_REQ = 2'd2
  } mem_state_t;

  // Read data returns MSB first, one byte per data phase.
  function automatic logic [7:0] return_lane(input logic [31:0] word, input logic [3:0] ph);
    case (ph)
      PH_D0:   return word[31:24];
      PH_D1:   return word[23:16];
      PH_D2:   return word[15:8];
      PH_D3:   return word[7:0];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/frame_phase_counter.sv
// rtl/frame_phase_counter.sv - free-running 0..9 frame phase counter with realignment load
module frame_phase_counter
  import bus_frame_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_sync,
  output logic [3:0] phase
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= PH_IDLE;
    end else if (frame_sync) begin
      phase <= PH_A0;
    end else if (phase >= 4'(FRAME_LEN - 1)) begin
      phase <= PH_IDLE;
    end else begin
      phase <= phase + 4'd1;
    end
  end

endmodule

// File: rtl/bus_frame_bridge.sv
// rtl/bus_frame_bridge.sv - decodes pin-multiplexed CPU frames into 32-bit memory accesses
module bus_frame_bridge
  import bus_frame_pkg::*;
#(
  parameter logic [7:0] IDLE_BYTE = 8'h00,
  parameter int          ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_sync,
  input  logic [7:0]        pin_addr,
  input  logic [7:0]        pin_data_in,
  output logic [7:0]        pin_data_out,
  output logic              pin_data_oe,
  output logic [3:0]        phase,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              frame_done,
  output logic              late_err
);

  logic [23:0] addr_buf;
  logic [23:0] wdata_buf;
  logic [31:0] addr_full;
  logic        we_l;
  logic [31:0] rbuf;
  logic [31:0] rbuf_next;
  logic        late_set;
  logic        ret_oe_next;
  logic [7:0]  ret_byte_next;
  mem_state_t  state;
  mem_state_t  state_next;

  frame_phase_counter u_phase (
    .clk        (clk),
    .rst        (rst),
    .frame_sync (frame_sync),
    .phase      (phase)
  );

  assign addr_full = {pin_addr, addr_buf};

  // mem_addr/mem_wdata update once per frame so a write still pending into
  // the next frame's address phases keeps a stable address and data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_buf  <= '0;
      wdata_buf <= '0;
      we_l      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (phase)
        PH_A0: begin
          addr_buf[7:0]  <= pin_addr;
          wdata_buf[7:0] <= pin_data_in;
        end
        PH_A1: begin
          addr_buf[15:8]  <= pin_addr;
          wdata_buf[15:8] <= pin_data_in;
        end
        PH_A2: begin
          addr_buf[23:16]  <= pin_addr;
          wdata_buf[23:16] <= pin_data_in;
        end
        PH_A3: begin
          mem_addr  <= addr_full[ADDR_W-1:0];
          mem_wdata <= {pin_data_in, wdata_buf};
        end
        PH_RW:   we_l <= pin_addr[0];
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next    = state;
    rbuf_next     = rbuf;
    late_set      = 1'b0;
    ret_oe_next   = 1'b0;
    ret_byte_next = IDLE_BYTE;
    mem_req       = (state != IDLE);
    mem_we        = (state == WR_REQ);

    if (phase == PH_A3) begin
      // Speculative read always takes the port; an unfinished write is lost.
      state_next = RD_REQ;
      if (state == WR_REQ && !mem_ready) begin
        late_set = 1'b1;
      end
    end else if (phase == PH_RW) begin
      state_next = pin_addr[0] ? WR_REQ : IDLE;
      if (mem_ready) begin
        rbuf_next = mem_rdata;
      end else begin
        rbuf_next = '0;
        late_set  = 1'b1;
      end
    end else if (state == WR_REQ && mem_ready) begin
      state_next = IDLE;
    end

    // The direction bit is still on the pins at the edge ending PH_RW.
    if (!frame_sync) begin
      if ((phase == PH_RW && !pin_addr[0]) ||
          (phase >= PH_D0 && phase <= PH_D2 && !we_l)) begin
        ret_oe_next   = 1'b1;
        ret_byte_next = return_lane(rbuf_next, phase + 4'd1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rbuf         <= '0;
      late_err     <= 1'b0;
      pin_data_oe  <= 1'b0;
      pin_data_out <= IDLE_BYTE;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_next;
      rbuf         <= rbuf_next;
      late_err     <= late_err | late_set;
      pin_data_oe  <= ret_oe_next;
      pin_data_out <= ret_byte_next;
      frame_done   <= (phase == PH_D3) && !frame_sync;
    end
  end

endmodule

// File: tb/tb_bus_frame_bridge.sv
// tb/tb_bus_frame_bridge.sv - directed frame-level checks of bus_frame_bridge
module tb_bus_frame_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_sync = 1'b0;
  logic [7:0]  pin_addr = 8'h00;
  logic [7:0]  pin_data_in = 8'h00;
  logic [7:0]  pin_data_out;
  logic        pin_data_oe;
  logic [3:0]  phase;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ready = 1'b0;
  logic        frame_done;
  logic        late_err;

  bus_frame_bridge #(
    .IDLE_BYTE (8'h00),
    .ADDR_W    (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_sync   (frame_sync),
    .pin_addr     (pin_addr),
    .pin_data_in  (pin_data_in),
    .pin_data_out (pin_data_out),
    .pin_data_oe  (pin_data_oe),
    .phase        (phase),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .frame_done   (frame_done),
    .late_err     (late_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic       obs_oe[10], obs_req[10], obs_we[10], obs_done[10], obs_late[10];
  logic [7:0] obs_out[10];
  logic       exp_oe[10], exp_req[10], exp_we[10], exp_done[10], exp_late[10];
  logic [7:0] exp_out[10];
  logic [31:0] obs_addr, obs_wdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pin_addr    = 8'h00;
    pin_data_in = 8'h00;
    mem_rdata   = 32'h0;
    mem_ready   = 1'b0;
  endtask

  // Enter from phase 0; walks phases 1..9,0 (or stops after observing stop_ph).
  task automatic run_frame(input logic [31:0] addr, input logic [31:0] data, input logic we,
                           input logic [31:0] rdata, input logic rd_ready,
                           input int ack_ph, input int stop_ph);
    step();
    for (int k = 1; k <= 10; k++) begin
      int ph;
      ph = k % 10;
      check_eq($sformatf("phase_p%0d", ph), 32'(phase), 32'(ph));
      pin_addr    = (ph >= 1 && ph <= 4) ? addr[8*(ph-1) +: 8] : ((ph == 5) ? {7'd0, we} : 8'h00);
      pin_data_in = (ph >= 1 && ph <= 4) ? data[8*(ph-1) +: 8] : 8'h00;
      mem_rdata   = (ph == 5) ? rdata : 32'h0;
      mem_ready   = (ph == 5 && rd_ready) || (ph == ack_ph);
      obs_oe[ph]   = pin_data_oe;
      obs_out[ph]  = pin_data_out;
      obs_req[ph]  = mem_req;
      obs_we[ph]   = mem_we;
      obs_done[ph] = frame_done;
      obs_late[ph] = late_err;
      if (ph == 6) begin
        obs_addr  = mem_addr;
        obs_wdata = mem_wdata;
      end
      if (ph == stop_ph) return;
      if (ph != 0) step();
    end
  endtask

  task automatic exp_clear(input logic late);
    for (int i = 0; i < 10; i++) begin
      exp_oe[i]   = 1'b0;
      exp_out[i]  = 8'h00;
      exp_req[i]  = 1'b0;
      exp_we[i]   = 1'b0;
      exp_done[i] = (i == 0);
      exp_late[i] = late;
    end
    exp_req[5] = 1'b1;
  endtask

  task automatic exp_read(input logic [31:0] rb);
    for (int i = 6; i <= 9; i++) exp_oe[i] = 1'b1;
    exp_out[6] = rb[31:24];
    exp_out[7] = rb[23:16];
    exp_out[8] = rb[15:8];
    exp_out[9] = rb[7:0];
  endtask

  task automatic check_frame(input string name);
    for (int i = 0; i < 10; i++) begin
      check_eq($sformatf("%s_oe_p%0d", name, i),   32'(obs_oe[i]),   32'(exp_oe[i]));
      check_eq($sformatf("%s_out_p%0d", name, i),  32'(obs_out[i]),  32'(exp_out[i]));
      check_eq($sformatf("%s_req_p%0d", name, i),  32'(obs_req[i]),  32'(exp_req[i]));
      check_eq($sformatf("%s_we_p%0d", name, i),   32'(obs_we[i]),   32'(exp_we[i]));
      check_eq($sformatf("%s_done_p%0d", name, i), 32'(obs_done[i]), 32'(exp_done[i]));
      check_eq($sformatf("%s_late_p%0d", name, i), 32'(obs_late[i]), 32'(exp_late[i]));
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    idle_inputs();
    repeat (cycles) @(posedge clk);
    #1;
    check_eq("rst_phase", 32'(phase), 32'd0);
    check_eq("rst_req", 32'(mem_req), 32'd0);
    check_eq("rst_oe", 32'(pin_data_oe), 32'd0);
    check_eq("rst_out", 32'(pin_data_out), 32'h00);
    check_eq("rst_late", 32'(late_err), 32'd0);
    check_eq("rst_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    do_reset(3);
    check_eq("rst_addr", mem_addr, 32'h0);
    check_eq("rst_wdata", mem_wdata, 32'h0);

    // Clean read: CA FE F0 0D returned MSB first.
    run_frame(32'h0000_0400, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b1, 15, -1);
    exp_clear(1'b0);
    exp_read(32'hCAFE_F00D);
    check_frame("rd");
    check_eq("rd_addr", obs_addr, 32'h0000_0400);

    // Write acknowledged in phase 7.
    run_frame(32'h1234_5600, 32'hDEAD_BEEF, 1'b1, 32'h5555_5555, 1'b1, 7, -1);
    exp_clear(1'b0);
    exp_req[6] = 1'b1; exp_we[6] = 1'b1;
    exp_req[7] = 1'b1; exp_we[7] = 1'b1;
    check_frame("wr");
    check_eq("wr_addr", obs_addr, 32'h1234_5600);
    check_eq("wr_wdata", obs_wdata, 32'hDEAD_BEEF);

    // Late read returns zeros and sets the sticky error.
    run_frame(32'h0000_0800, 32'h0, 1'b0, 32'hFFFF_FFFF, 1'b0, 15, -1);
    exp_clear(1'b0);
    exp_read(32'h0);
    for (int i = 6; i <= 9; i++) exp_late[i] = 1'b1;
    exp_late[0] = 1'b1;
    check_frame("late");

    run_frame(32'h0000_0C00, 32'h0, 1'b0, 32'h1122_3344, 1'b1, 15, -1);
    exp_clear(1'b1);
    exp_read(32'h1122_3344);
    check_frame("sticky");

    do_reset(2);

    // Unacknowledged write is dropped when the next speculative read starts.
    run_frame(32'hA5A5_A5A4, 32'h0102_0304, 1'b1, 32'h0, 1'b1, 15, -1);
    exp_clear(1'b0);
    for (int i = 6; i <= 9; i++) begin exp_req[i] = 1'b1; exp_we[i] = 1'b1; end
    exp_req[0] = 1'b1; exp_we[0] = 1'b1;
    check_frame("wr_hang");
    check_eq("wr_hang_wdata", obs_wdata, 32'h0102_0304);

    run_frame(32'h0000_1000, 32'h0, 1'b0, 32'h0BAD_F00D, 1'b1, 15, -1);
    exp_clear(1'b0);
    exp_read(32'h0BAD_F00D);
    for (int i = 1; i <= 4; i++) begin exp_req[i] = 1'b1; exp_we[i] = 1'b1; end
    for (int i = 5; i <= 9; i++) exp_late[i] = 1'b1;
    exp_late[0] = 1'b1;
    check_frame("wr_drop");
    check_eq("wr_drop_addr", obs_addr, 32'h0000_1000);

    // frame_sync during phase 7 of a read.
    run_frame(32'h0000_2000, 32'h0, 1'b0, 32'h89AB_CDEF, 1'b1, 15, 7);
    check_eq("sync_pre_oe", 32'(pin_data_oe), 32'd1);
    check_eq("sync_pre_out", 32'(pin_data_out), 32'hAB);
    frame_sync = 1'b1;
    idle_inputs();
    step();
    frame_sync = 1'b0;
    check_eq("sync_phase", 32'(phase), 32'd1);
    check_eq("sync_oe", 32'(pin_data_oe), 32'd0);
    check_eq("sync_out", 32'(pin_data_out), 32'h00);
    repeat (9) step();
    check_eq("sync_realign", 32'(phase), 32'd0);

    // Asynchronous reset in the middle of phase 7: pending write and read return.
    run_frame(32'h0000_3000, 32'hCAFE_BABE, 1'b1, 32'h0, 1'b1, 15, 7);
    check_eq("arst_wr_pre_req", 32'(mem_req), 32'd1);
    check_eq("arst_wr_pre_we", 32'(mem_we), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_wr_req", 32'(mem_req), 32'd0);
    check_eq("arst_wr_we", 32'(mem_we), 32'd0);
    check_eq("arst_wr_phase", 32'(phase), 32'd0);
    do_reset(1);

    run_frame(32'h0000_4000, 32'h0, 1'b0, 32'h0F1E_2D3C, 1'b1, 15, 7);
    check_eq("arst_rd_pre_oe", 32'(pin_data_oe), 32'd1);
    check_eq("arst_rd_pre_out", 32'(pin_data_out), 32'h1E);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_rd_oe", 32'(pin_data_oe), 32'd0);
    check_eq("arst_rd_out", 32'(pin_data_out), 32'h00);
    check_eq("arst_rd_req", 32'(mem_req), 32'd0);
    do_reset(1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
